// File: rtl/game_countdown_timer.sv
// 4-digit BCD countdown with bonus add, pause and expiry; all outputs registered, one-cycle latency.
// No backpressure: every tick/pulse is acted on in the cycle it arrives (a decrement that collides with an add is deferred one cycle).
module game_countdown_timer #(
  parameter logic [15:0] INIT_TIME  = 16'h0060,
  parameter logic [15:0] LOW_THRESH = 16'h0010
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_pause,
  input  logic            i_one_sec,
  input  logic            i_add_time,
  input  logic [3:0][3:0] i_time_to_add,
  output logic [3:0][3:0] o_timer_digit,
  output logic            o_running,
  output logic            o_low_time,
  output logic            o_time_up,
  output logic            o_time_up_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_EXPIRED} state_t;

  state_t      r_state;
  logic [15:0] r_value;
  logic        r_pending;
  logic [15:0] w_add;
  logic [15:0] w_dec;

  // Addend digits above 9 are clamped; a carry out of the thousands digit saturates.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic        carry;
    logic [3:0]  bd;
    logic [4:0]  d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bd = (b[i*4 +: 4] > 4'd9) ? 4'd9 : b[i*4 +: 4];
      d  = {1'b0, a[i*4 +: 4]} + {1'b0, bd} + {4'b0, carry};
      if (d > 5'd9) begin
        sum[i*4 +: 4] = 4'(d - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[i*4 +: 4] = d[3:0];
        carry         = 1'b0;
      end
    end
    return carry ? 16'h9999 : sum;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] a);
    logic [15:0] res;
    logic        borrow;
    res    = a;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (a[i*4 +: 4] == 4'd0) begin
          res[i*4 +: 4] = 4'd9;
        end else begin
          res[i*4 +: 4] = a[i*4 +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_add         = bcd_add_sat(r_value, i_time_to_add);
  assign w_dec         = bcd_dec(r_value);
  assign o_timer_digit = r_value;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_value         <= 16'h0000;
      r_pending       <= 1'b0;
      o_running       <= 1'b0;
      o_low_time      <= 1'b0;
      o_time_up       <= 1'b0;
      o_time_up_pulse <= 1'b0;
    end else begin
      o_time_up_pulse <= 1'b0;
      if (i_start) begin
        r_state    <= S_RUNNING;
        r_value    <= INIT_TIME;
        r_pending  <= 1'b0;
        o_running  <= 1'b1;
        o_time_up  <= 1'b0;
        o_low_time <= (INIT_TIME < LOW_THRESH);
      end else begin
        case (r_state)
          S_RUNNING: begin
            if (i_add_time) begin
              // Add wins this cycle; any tick is remembered and applied next cycle.
              r_value    <= w_add;
              o_low_time <= (w_add < LOW_THRESH);
              r_pending  <= (i_one_sec | r_pending) & ~i_pause;
              if (i_pause) r_state <= S_PAUSED;
            end else if (i_pause) begin
              r_state   <= S_PAUSED;
              r_pending <= 1'b0;
            end else if (i_one_sec || r_pending) begin
              r_pending <= 1'b0;
              if (r_value == 16'h0001) begin
                r_state         <= S_EXPIRED;
                r_value         <= 16'h0000;
                o_running       <= 1'b0;
                o_low_time      <= 1'b0;
                o_time_up       <= 1'b1;
                o_time_up_pulse <= 1'b1;
              end else begin
                r_value    <= w_dec;
                o_low_time <= (w_dec < LOW_THRESH);
              end
            end
          end
          S_PAUSED: begin
            if (i_add_time) begin
              r_value    <= w_add;
              o_low_time <= (w_add < LOW_THRESH);
            end
            if (!i_pause) r_state <= S_RUNNING;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
